// File: rtl/tmds_encoder_pipelined.sv
// rtl/tmds_encoder_pipelined.sv - DVI TMDS 8b/10b encoder for one colour lane, two register stages
// Stage 1 does transition minimisation; stage 2 does DC balancing against the running disparity.
module tmds_encoder_pipelined #(
   parameter int C_disparity_bits = 5
) (
   input  logic                               clk_pixel,
   input  logic                               reset,
   input  logic [7:0]                         in_data,
   input  logic [1:0]                         in_c,
   input  logic                               in_blank,
   output logic [9:0]                         out_tmds,
   output logic signed [C_disparity_bits-1:0] out_disparity
);

   localparam int W = C_disparity_bits;
   localparam logic signed [W-1:0] C_zero  = '0;
   localparam logic signed [W-1:0] C_two   = W'(2);
   localparam logic signed [W-1:0] C_eight = W'(8);

   logic [3:0] n1d;
   logic       use_xnor;
   logic [8:0] q_m;
   logic [3:0] n1q;

   always_comb begin
      n1d = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n1d = n1d + {3'd0, in_data[i]};
      end
      use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !in_data[0]);
      q_m      = 9'd0;
      q_m[0]   = in_data[0];
      for (int i = 1; i < 8; i++) begin
         q_m[i] = use_xnor ? ~(q_m[i-1] ^ in_data[i]) : (q_m[i-1] ^ in_data[i]);
      end
      q_m[8] = ~use_xnor;
      n1q    = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n1q = n1q + {3'd0, q_m[i]};
      end
   end

   logic [8:0] s1_qm;
   logic [3:0] s1_n1q;
   logic       s1_blank;
   logic [1:0] s1_c;

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         s1_qm    <= 9'd0;
         s1_n1q   <= 4'd0;
         s1_blank <= 1'b1;
         s1_c     <= 2'b00;
      end else begin
         s1_qm    <= q_m;
         s1_n1q   <= n1q;
         s1_blank <= in_blank;
         s1_c     <= in_c;
      end
   end

   // ones_minus_zeros = N1q - N0q = 2*N1q - 8
   logic signed [W-1:0] ones_minus_zeros;
   logic signed [W-1:0] cnt_next;
   logic [9:0]          tmds_next;

   assign ones_minus_zeros = $signed(W'({s1_n1q, 1'b0})) - C_eight;

   always_comb begin
      tmds_next = 10'h354;
      cnt_next  = C_zero;
      if (s1_blank) begin
         case (s1_c)
            2'b00:   tmds_next = 10'h354;
            2'b01:   tmds_next = 10'h0AB;
            2'b10:   tmds_next = 10'h154;
            default: tmds_next = 10'h2AB;
         endcase
         cnt_next = C_zero;
      end else if ((out_disparity == C_zero) || (s1_n1q == 4'd4)) begin
         tmds_next = {~s1_qm[8], s1_qm[8], s1_qm[8] ? s1_qm[7:0] : ~s1_qm[7:0]};
         cnt_next  = s1_qm[8] ? (out_disparity + ones_minus_zeros)
                              : (out_disparity - ones_minus_zeros);
      end else if (((out_disparity > C_zero) && (s1_n1q > 4'd4)) ||
                   ((out_disparity < C_zero) && (s1_n1q < 4'd4))) begin
         tmds_next = {1'b1, s1_qm[8], ~s1_qm[7:0]};
         cnt_next  = out_disparity + (s1_qm[8] ? C_two : C_zero) - ones_minus_zeros;
      end else begin
         tmds_next = {1'b0, s1_qm[8], s1_qm[7:0]};
         cnt_next  = out_disparity - (s1_qm[8] ? C_zero : C_two) + ones_minus_zeros;
      end
   end

   // The output disparity register doubles as the running counter.
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         out_tmds      <= 10'h354;
         out_disparity <= C_zero;
      end else begin
         out_tmds      <= tmds_next;
         out_disparity <= cnt_next;
      end
   end

endmodule

// File: tb/tb_tmds_encoder_pipelined.sv
// tb/tb_tmds_encoder_pipelined.sv - scoreboard bench for tmds_encoder_pipelined
// Directed golden symbols plus randomized traffic checked against an arithmetic reference and a decoder.
module tb_tmds_encoder_pipelined;

   logic              clk_pixel = 1'b0;
   logic              reset     = 1'b1;
   logic [7:0]        in_data   = 8'h00;
   logic [1:0]        in_c      = 2'b00;
   logic              in_blank  = 1'b1;
   logic [9:0]        out_tmds;
   logic signed [4:0] out_disparity;

   tmds_encoder_pipelined #(.C_disparity_bits(5)) dut (
      .clk_pixel     (clk_pixel),
      .reset         (reset),
      .in_data       (in_data),
      .in_c          (in_c),
      .in_blank      (in_blank),
      .out_tmds      (out_tmds),
      .out_disparity (out_disparity)
   );

   always #5 clk_pixel = ~clk_pixel;

   typedef struct {
      int         due;
      logic [9:0] tmds;
      int         disp;
      bit         decode;
      bit         blank;
      logic [1:0] c;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];
   int   edge_cnt  = 0;
   int   n_checks  = 0;
   int   n_fail    = 0;
   int   m_cnt     = 0;

   always @(posedge clk_pixel) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_cnt, act, exp);
      end
   endtask

   // TMDS reference: q_m bits are prefix parities, inverted at odd positions for the XNOR flavour.
   function automatic logic [9:0] ref_encode(input bit blank, input logic [1:0] c, input logic [7:0] d);
      logic [8:0] qm;
      logic [7:0] mask;
      int         n1, n1q, n0q;
      bit         use_xnor;
      if (blank) begin
         m_cnt = 0;
         case (c)
            2'b00:   return 10'h354;
            2'b01:   return 10'h0AB;
            2'b10:   return 10'h154;
            default: return 10'h2AB;
         endcase
      end
      n1       = $countones(d);
      use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
      for (int i = 0; i < 8; i++) begin
         mask  = 8'((1 << (i + 1)) - 1);
         qm[i] = (^(d & mask)) ^ (use_xnor && (i % 2 == 1));
      end
      qm[8] = !use_xnor;
      n1q   = $countones(qm[7:0]);
      n0q   = 8 - n1q;
      if (m_cnt == 0 || n1q == n0q) begin
         m_cnt += qm[8] ? (n1q - n0q) : (n0q - n1q);
         return {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      end else if ((m_cnt > 0 && n1q > n0q) || (m_cnt < 0 && n0q > n1q)) begin
         m_cnt += 2 * int'(qm[8]) + (n0q - n1q);
         return {1'b1, qm[8], ~qm[7:0]};
      end else begin
         m_cnt += -2 * int'(!qm[8]) + (n1q - n0q);
         return {1'b0, qm[8], qm[7:0]};
      end
   endfunction

   // Receiver-side decode packed as {blank, c, data}.
   function automatic int decode(input logic [9:0] s);
      logic [7:0] b, d;
      case (s)
         10'h354: return {1'b1, 2'b00, 8'h00};
         10'h0AB: return {1'b1, 2'b01, 8'h00};
         10'h154: return {1'b1, 2'b10, 8'h00};
         10'h2AB: return {1'b1, 2'b11, 8'h00};
         default: ;
      endcase
      b    = s[9] ? ~s[7:0] : s[7:0];
      d[0] = b[0];
      for (int i = 1; i < 8; i++) d[i] = s[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
      return {1'b0, 2'b00, d};
   endfunction

   task automatic drive(input bit rst, input bit blank, input logic [1:0] c, input logic [7:0] d);
      exp_t e;
      @(posedge clk_pixel);
      #1;
      reset    = rst;
      in_blank = blank;
      in_c     = c;
      in_data  = d;
      e.due    = edge_cnt + 2;
      e.blank  = blank;
      e.c      = c;
      e.data   = d;
      if (rst) begin
         m_cnt = 0;
         if (sb.size() > 0 && sb[sb.size()-1].due == edge_cnt + 1) begin
            sb[sb.size()-1].tmds   = 10'h354;
            sb[sb.size()-1].disp   = 0;
            sb[sb.size()-1].decode = 1'b0;
         end
         e.tmds   = 10'h354;
         e.disp   = 0;
         e.decode = 1'b0;
      end else begin
         e.tmds   = ref_encode(blank, c, d);
         e.disp   = m_cnt;
         e.decode = 1'b1;
      end
      sb.push_back(e);
   endtask

   task automatic drive_gold(input bit blank, input logic [1:0] c, input logic [7:0] d,
                             input logic [9:0] g_tmds, input int g_disp);
      drive(1'b0, blank, c, d);
      sb[sb.size()-1].tmds = g_tmds;
      sb[sb.size()-1].disp = g_disp;
   endtask

   always @(negedge clk_pixel) begin
      exp_t e;
      int   act_disp;
      if (sb.size() > 0 && sb[0].due <= edge_cnt) begin
         e        = sb.pop_front();
         act_disp = int'(out_disparity);
         check("due_edge", e.due, edge_cnt);
         check("tmds", int'(out_tmds), int'(e.tmds));
         check("disparity", act_disp, e.disp);
         check("disparity_bound", int'(act_disp >= -10 && act_disp <= 10), 1);
         if (e.decode) begin
            check("decode", decode(out_tmds),
                  int'({e.blank, e.blank ? e.c : 2'b00, e.blank ? 8'h00 : e.data}));
            if (e.blank) check("blank_disp_zero", act_disp, 0);
         end
      end
   end

   initial begin
      bit blank_state;
      repeat (3) drive(1'b1, 1'b1, 2'b00, 8'h00);
      repeat (2) drive_gold(1'b1, 2'b00, 8'h00, 10'h354, 0);
      drive_gold(1'b1, 2'b00, 8'h00, 10'h354, 0);
      drive_gold(1'b1, 2'b01, 8'h00, 10'h0AB, 0);
      drive_gold(1'b1, 2'b10, 8'h00, 10'h154, 0);
      drive_gold(1'b1, 2'b11, 8'h00, 10'h2AB, 0);
      drive_gold(1'b1, 2'b00, 8'h00, 10'h354, 0);
      drive_gold(1'b0, 2'b00, 8'h00, 10'h100, -8);
      drive_gold(1'b0, 2'b00, 8'h00, 10'h3FF, 2);
      drive_gold(1'b0, 2'b00, 8'h00, 10'h100, -6);
      drive_gold(1'b1, 2'b00, 8'h00, 10'h354, 0);
      drive_gold(1'b0, 2'b00, 8'hFF, 10'h200, -8);
      drive_gold(1'b1, 2'b00, 8'h00, 10'h354, 0);
      drive_gold(1'b0, 2'b00, 8'h00, 10'h100, -8);
      drive_gold(1'b0, 2'b00, 8'h00, 10'h3FF, 2);
      drive(1'b1, 1'b0, 2'b00, 8'h00);
      drive_gold(1'b0, 2'b00, 8'h00, 10'h100, -8);
      drive_gold(1'b0, 2'b00, 8'h00, 10'h3FF, 2);

      blank_state = 1'b0;
      for (int n = 0; n < 10000; n++) begin
         if ($urandom_range(0, 99) < 6) blank_state = !blank_state;
         drive(($urandom_range(0, 999) == 0), blank_state, 2'($urandom), 8'($urandom));
      end
      repeat (3) drive(1'b0, 1'b1, 2'b00, 8'h00);

      repeat (4) @(posedge clk_pixel);
      @(negedge clk_pixel);
      #1;
      check("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
